// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its backing RAM.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } mem_op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 2**ADDR_W words, registered read, no reset.
// The read register samples every cycle (read-before-write on a shared index);
// the responder decides when the sampled word is meaningful.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  // Write port and registered read port share one index.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read or write, completes it after
// LATENCY cycles with a one-cycle mem_ready_o pulse, and counts completions.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_req_i,
  input  logic              wr_req_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              mem_ready_o,
  output logic              busy_o,
  output logic              conflict_o,
  output logic [CNT_W-1:0]  no_rd_o,
  output logic [CNT_W-1:0]  no_wr_o
);

  localparam logic [7:0]       LAT_INIT = 8'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  mem_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [7:0]        lat_cnt_q, lat_cnt_d;
  logic              conflict_q, conflict_d;
  logic [CNT_W-1:0]  no_rd_q, no_rd_d;
  logic [CNT_W-1:0]  no_wr_q, no_wr_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;
  logic              mem_ready;
  logic              busy;

  // Byte-offset bits and bits above the word index are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // State, latched request and counters; asynchronous reset leaves RAM untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      idx_q      <= '0;
      wdata_q    <= '0;
      lat_cnt_q  <= '0;
      conflict_q <= 1'b0;
      no_rd_q    <= '0;
      no_wr_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      lat_cnt_q  <= lat_cnt_d;
      conflict_q <= conflict_d;
      no_rd_q    <= no_rd_d;
      no_wr_q    <= no_wr_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state and output logic; the RAM operation fires on the WAIT->RESP edge.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    lat_cnt_d  = lat_cnt_q;
    conflict_d = conflict_q;
    no_rd_d    = no_rd_q;
    no_wr_d    = no_wr_q;
    rdata_d    = rdata_q;
    ram_we     = 1'b0;
    mem_ready  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req_i || wr_req_i) begin
          state_d   = WAIT;
          op_d      = wr_req_i ? OP_WR : OP_RD;
          idx_d     = addr_i[ADDR_W+1:2];
          wdata_d   = wdata_i;
          lat_cnt_d = LAT_INIT;
          if (rd_req_i && wr_req_i) begin
            conflict_d = 1'b1;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_cnt_q == 8'd0) begin
          state_d = RESP;
          ram_we  = (op_q == OP_WR);
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end
      end
      RESP: begin
        busy      = 1'b1;
        mem_ready = 1'b1;
        state_d   = IDLE;
        if (op_q == OP_WR) begin
          no_wr_d = no_wr_q + CNT_ONE;
        end else begin
          no_rd_d = no_rd_q + CNT_ONE;
          rdata_d = ram_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // During a read's RESP cycle the fresh RAM word is shown; otherwise the last read is held.
  assign rdata_o     = (state_q == RESP && op_q == OP_RD) ? ram_rdata : rdata_q;
  assign mem_ready_o = mem_ready;
  assign busy_o      = busy;
  assign conflict_o  = conflict_q;
  assign no_rd_o     = no_rd_q;
  assign no_wr_o     = no_wr_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder that serves the data cache's refill reads and dirty-line write-backs.
- It accepts one read or write request at a time and completes it after a programmable latency by pulsing mem_ready_o. Read data is returned on rdata_o.
- It sits between the cache's memory-request outputs (address, write enable, write-back data, read request) and the cache's data_mem and mem_ready inputs. It replaces a zero-latency LSU memory, so cache miss and stall behaviour can be exercised.

Parameters:
- ADDR_W, 10, word-index width; backing array holds 2**ADDR_W 32-bit words.
- LATENCY, 4, cycles from request acceptance to mem_ready_o; legal range 1..255.
- CNT_W, 32, width of the activity counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- rd_req_i  in  1  read request, level-sensitive.
- wr_req_i  in  1  write request, level-sensitive.
- addr_i  in  32  byte address; bits [ADDR_W+1:2] select the word.
- wdata_i  in  32  write data, sampled at acceptance.
- rdata_o  out  32  read data; valid while mem_ready_o=1, held until the next read completes.
- mem_ready_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in WAIT and RESP.
- conflict_o  out  1  sticky flag: rd_req_i and wr_req_i were both high at an acceptance.
- no_rd_o  out  CNT_W  count of completed reads.
- no_wr_o  out  CNT_W  count of completed writes.

Behaviour:
- Reset values (asynchronous, while rst_i=1):
  - state=IDLE
  - mem_ready_o=0, busy_o=0, conflict_o=0
  - rdata_o=0
  - no_rd_o=0, no_wr_o=0
  - latency counter=0
  - The backing array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If rd_req_i or wr_req_i is high at a rising edge, the request is accepted. addr_i, wdata_i and the operation type are latched, lat_cnt is loaded with LATENCY-1, and the FSM goes to WAIT.
  - Otherwise the FSM stays in IDLE.
- WAIT:
  - lat_cnt decrements each cycle.
  - When lat_cnt==0, the FSM goes to RESP and the operation executes at that edge:
    - Write: mem[idx] <= latched wdata.
    - Read: rdata_o <= mem[idx].
- RESP:
  - mem_ready_o=1 for exactly this one cycle.
  - The matching counter (no_rd_o or no_wr_o) increments at the edge leaving RESP.
  - The FSM always returns to IDLE.
- Latency:
  - With acceptance at edge N, mem_ready_o is high in the cycle after edge N+LATENCY.
  - With LATENCY=1 there is one WAIT cycle; total occupancy is LATENCY+1 cycles per transaction.
- Request rules:
  - Request inputs are ignored outside IDLE, so changes to addr_i and wdata_i during WAIT and RESP have no effect.
  - The requester deasserts its request in the RESP cycle.
  - A request still high in the following IDLE cycle is accepted as a new transaction. This is intended for back-to-back misses.
- Simultaneous rd_req_i and wr_req_i at acceptance: the transaction is executed as a write, and conflict_o is set to 1. conflict_o clears only on reset.
- Address handling:
  - addr_i[1:0] is ignored (word access only).
  - Bits above ADDR_W+1 are ignored, so the address wraps modulo 2**ADDR_W words.
- Counters wrap at 2**CNT_W with no saturation.
- Reset mid-transaction (rst_i asserted in WAIT or RESP):
  - Immediate return to IDLE; no mem_ready_o pulse is produced.
  - A write that had not yet reached the WAIT->RESP edge is not performed.
- Read-after-write to the same index in consecutive transactions returns the new data, because there is no write buffer.

Decomposition:
- Shared package mem_pkg:
  - typedef enum {IDLE, WAIT, RESP} mem_state_e;
  - typedef enum {OP_RD, OP_WR} mem_op_e;
  - localparam WORD_W=32.
- One natural sub-module, mem_array: single-port 2**ADDR_W x 32 synchronous RAM with we, idx, wdata and registered rdata, and no reset. The FSM, latency counter and activity counters stay in mem_responder.

Test Plan:
- Write then read, LATENCY=4:
  - Stimulus: wr_req_i with addr_i=0x0000_0040, wdata_i=0xDEAD_BEEF; after mem_ready_o, rd_req_i with the same address.
  - Required: each mem_ready_o pulse is exactly 1 cycle wide, 5 cycles after acceptance; rdata_o=0xDEAD_BEEF; no_wr_o=1, no_rd_o=1.
- LATENCY=1 back-to-back:
  - Stimulus: rd_req_i held high continuously for 3 transactions.
  - Required: mem_ready_o pulses every 3 cycles (IDLE, WAIT, RESP); no_rd_o=3.
- Address wrap and alignment, ADDR_W=10:
  - Stimulus: write 0x1234_5678 to addr 0x0000_1003, then read addr 0x0000_0000.
  - Required: rdata_o=0x1234_5678.
- Conflict:
  - Stimulus: rd_req_i=wr_req_i=1, addr 0x80, wdata 0xA5A5_A5A5; then read 0x80.
  - Required: the transaction is a write; conflict_o=1 and stays 1; the read returns 0xA5A5_A5A5.
- Reset mid-write:
  - Setup: write 0x1111_1111 to 0x10.
  - Stimulus: write 0x2222_2222 to 0x10; assert rst_i 2 cycles after acceptance (LATENCY=4).
  - Required: mem_ready_o stays 0; all outputs are 0; a subsequent read of 0x10 returns 0x1111_1111.
- Input changes during WAIT:
  - Stimulus: change addr_i and wdata_i during WAIT.
  - Required: the write lands at the originally latched address with the latched data.
